fifo_pop_ctrl: RTL and testbench

//  Flow-control stage directly downstream of the main FIFO.

---
 rtl/fifo_pop_ctrl_pkg.sv | 14 +
 rtl/pop_skid_buf.sv | 45 ++++
 rtl/fifo_pop_ctrl.sv | 141 ++++++++++++++
 tb/tb_fifo_pop_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pop_ctrl_pkg.sv
// Shared FSM encoding for the FIFO pop controller.
package fifo_pop_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/pop_skid_buf.sv
// Two-entry FIFO-ordered skid buffer holding words popped from the main FIFO.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module pop_skid_buf #(
  parameter int DATA_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] din,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] dout,
  output logic [1:0]           count
);

  logic [DATA_SIZE-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_pop_ctrl.sv
// FIFO pop controller: issues registered pops, skids popped words, flags a stalled full FIFO.
// Define POP_STATS_EN to add the 16-bit pop_count output.
module fifo_pop_ctrl
  import fifo_pop_ctrl_pkg::*;
#(
  parameter int DATA_SIZE  = 6,
  parameter int COUNT_SIZE = 4,
  parameter int UMB_AF_DEF = 6,
  parameter int UMB_AE_DEF = 3,
  parameter int ERR_LIMIT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [COUNT_SIZE-1:0] umb_af_in,
  input  logic [COUNT_SIZE-1:0] umb_ae_in,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic [COUNT_SIZE-1:0] data_count,
  input  logic [DATA_SIZE-1:0]  buff_out,
  input  logic                  ready_in,
  output logic                  read,
  output logic [COUNT_SIZE-1:0] umb_almost_full,
  output logic [COUNT_SIZE-1:0] umb_almost_empty,
  output logic [DATA_SIZE-1:0]  data_out,
  output logic                  valid_out,
  output logic [STATE_W-1:0]    state,
  output logic                  idle_out,
  output logic                  error_out
`ifdef POP_STATS_EN
  ,
  output logic [15:0]           pop_count
`endif
);

  localparam int STALL_W = $clog2(ERR_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(ERR_LIMIT);

  state_t               state_q, state_d;
  logic                 read_q, read_d;
  logic                 inflight_q;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [1:0]           skid_count;
  logic [2:0]           pending;
  logic                 flush, push, xfer, err_hit;
  logic                 data_count_unused;

  // Occupancy is observed for debug only; the pop decision uses fifo_empty.
  assign data_count_unused = ^data_count;

  // Handshake: a word leaves on every rising edge where valid_out && ready_in;
  // valid_out only drops without a transfer on INIT, ERROR or reset.
  assign flush     = (state_q == ST_INIT);
  assign valid_out = (skid_count != 2'd0) && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
  assign xfer      = valid_out && ready_in;
  assign push      = inflight_q && !flush;

  // Words already committed to the skid once this edge's transfer is taken out;
  // a new pop is safe only if it still fits with no further transfers.
  assign pending = {1'b0, skid_count} + {2'b00, inflight_q} + {2'b00, read_q} - {2'b00, xfer};

  pop_skid_buf #(.DATA_SIZE(DATA_SIZE)) u_skid (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .din   (buff_out),
    .pop   (xfer),
    .dout  (data_out),
    .count (skid_count)
  );

  always_comb begin
    stall_d = '0;
    if ((state_q != ST_RESET) && (state_q != ST_INIT) && fifo_full && !read_q) begin
      stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
    end
  end

  assign err_hit = (stall_d == STALL_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (err_hit)          state_d = ST_ERROR;
        else if (!fifo_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err_hit) state_d = ST_ERROR;
        else if (fifo_empty && (skid_count == 2'd0) && !inflight_q && !read_q) state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_INIT;
    endcase
    if (init && (state_q != ST_RESET)) state_d = ST_INIT;
  end

  assign read_d = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) && !fifo_empty && (pending < 3'd2);

  // A pop that meets an already-empty FIFO is dropped by the FIFO, so it never goes in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_RESET;
      read_q           <= 1'b0;
      inflight_q       <= 1'b0;
      stall_q          <= '0;
      umb_almost_full  <= COUNT_SIZE'(UMB_AF_DEF);
      umb_almost_empty <= COUNT_SIZE'(UMB_AE_DEF);
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      inflight_q <= (state_q == ST_INIT) ? 1'b0 : (read_q && !fifo_empty);
      stall_q    <= stall_d;
      if (state_q == ST_INIT) begin
        umb_almost_full  <= umb_af_in;
        umb_almost_empty <= umb_ae_in;
      end
    end
  end

`ifdef POP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_count <= 16'd0;
    end else if (state_q == ST_INIT) begin
      pop_count <= 16'd0;
    end else if (read_q) begin
      pop_count <= pop_count + 16'd1;
    end
  end
`endif

  assign read      = read_q;
  assign state     = state_q;
  assign idle_out  = (state_q == ST_IDLE);
  assign error_out = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed bench for fifo_pop_ctrl with a behavioural FIFO and an in-order scoreboard.
module tb_fifo_pop_ctrl;

  localparam int DW = 6;
  localparam int CW = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          init;
  logic [CW-1:0] umb_af_in, umb_ae_in;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] data_count;
  logic [DW-1:0] buff_out;
  logic          ready_in;
  logic          read;
  logic [CW-1:0] umb_almost_full, umb_almost_empty;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [2:0]    state;
  logic          idle_out, error_out;
`ifdef POP_STATS_EN
  logic [15:0]   pop_count;
`endif

  fifo_pop_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .umb_af_in        (umb_af_in),
    .umb_ae_in        (umb_ae_in),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .data_count       (data_count),
    .buff_out         (buff_out),
    .ready_in         (ready_in),
    .read             (read),
    .umb_almost_full  (umb_almost_full),
    .umb_almost_empty (umb_almost_empty),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .state            (state),
    .idle_out         (idle_out),
    .error_out        (error_out)
`ifdef POP_STATS_EN
    ,
    .pop_count        (pop_count)
`endif
  );

  // scoreboard and monitor state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  pop_seen = 0;
  int  read_cyc = 0;
  int  run = 0;
  int  max_run = 0;
  int  first_read = -1;
  int  first_valid = -1;
  int  first_active = -1;
  bit  mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, advance the FIFO model on the edge, return at posedge+1.
  task automatic step();
    logic          pop_now;
    logic [DW-1:0] word;
    @(negedge clk);
    cyc++;
    pop_now = read && !fifo_empty && (fifo_q.size() > 0);
    if (read) begin
      read_cyc++;
      run++;
      if (run > max_run) max_run = run;
      if (first_read < 0) first_read = cyc;
    end else begin
      run = 0;
    end
    if (pop_now) pop_seen++;
    if (valid_out && first_valid < 0) first_valid = cyc;
    if (state == 3'd3 && first_active < 0) first_active = cyc;
    if (mon_en && valid_out && ready_in) begin
      if (exp_q.size() == 0) check("xfer_extra", 32'd1, 32'd0);
      else                   check("xfer_data", data_out, exp_q.pop_front());
    end
    word = buff_out;
    if (pop_now) word = fifo_q.pop_front();
    @(posedge clk);
    buff_out   <= word;
    fifo_empty <= (fifo_q.size() == 0);
    data_count <= 4'(fifo_q.size());
    #1;
  endtask

  task automatic load_words();
    for (int i = 0; i < 11; i++) begin
      fifo_q.push_back(6'(3 + i));
      exp_q.push_back(6'(3 + i));
    end
  endtask

  initial begin
    int p0;
    int n_low;
    int rc_base;
    bit hit;

    reset = 1'b1; init = 1'b0; umb_af_in = '0; umb_ae_in = '0;
    fifo_empty = 1'b1; fifo_full = 1'b0; data_count = '0; buff_out = '0; ready_in = 1'b0;

    // 1: reset values
    repeat (2) step();
    check("rst_read", read, 1'b0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_data", data_out, 6'd0);
    check("rst_state", state, 3'd0);
    check("rst_idle", idle_out, 1'b0);
    check("rst_error", error_out, 1'b0);
    check("rst_af", umb_almost_full, 4'd6);
    check("rst_ae", umb_almost_empty, 4'd3);
    reset = 1'b0;
    #1;
    check("rel_state0", state, 3'd0);
    step();
    check("rel_state1", state, 3'd1);

    // 2: threshold latching
    init = 1'b1; umb_af_in = 4'd9; umb_ae_in = 4'd2;
    step();
    check("init_hold", state, 3'd1);
    init = 1'b0;
    step();
    check("init_af9", umb_almost_full, 4'd9);
    check("init_ae2", umb_almost_empty, 4'd2);
    check("init_idle", state, 3'd2);
    init = 1'b1; umb_af_in = 4'd6; umb_ae_in = 4'd3;
    step();
    check("init2_state", state, 3'd1);
    check("init2_af_not_yet", umb_almost_full, 4'd9);
    init = 1'b0;
    step();
    check("init2_af6", umb_almost_full, 4'd6);
    check("init2_ae3", umb_almost_empty, 4'd3);
    check("init2_state_idle", state, 3'd2);
    check("init2_idle_out", idle_out, 1'b1);

    // 3: stream 11 words with ready_in=1
    rc_base = read_cyc;
    p0 = pop_seen;
    first_read = -1; first_valid = -1; first_active = -1; max_run = 0; run = 0;
    load_words();
    ready_in = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    check("t3_drained", exp_q.size(), 0);
    repeat (3) step();
    check("t3_pops", pop_seen - p0, 11);
    check("t3_lat_read", first_read - first_active, 1);
    check("t3_lat_valid", first_valid - first_read, 2);
    check("t3_b2b_read", (max_run >= 2), 1'b1);
    check("t3_state_idle", state, 3'd2);
    check("t3_valid_low", valid_out, 1'b0);
`ifdef POP_STATS_EN
    check("t3_pop_count", pop_count, read_cyc - rc_base);
`endif

    // 4: downstream stalled, then released
    p0 = pop_seen;
    ready_in = 1'b0;
    load_words();
    repeat (12) step();
    check("t4_two_pops", pop_seen - p0, 2);
    check("t4_read_low", read, 1'b0);
    check("t4_valid", valid_out, 1'b1);
    check("t4_head", data_out, 6'h3);
    check("t4_active", state, 3'd3);
    ready_in = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    check("t4_drained", exp_q.size(), 0);
    repeat (3) step();
    check("t4_pops", pop_seen - p0, 11);
    check("t4_state_idle", state, 3'd2);

    // 5: full FIFO with no pops raises ERROR
    ready_in = 1'b0;
    fifo_full = 1'b1;
    load_words();
    n_low = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (state == 3'd4)  hit = 1'b1;
      else if (!read)     n_low++;
      else                n_low = 0;
    end
    check("t5_error_state", state, 3'd4);
    check("t5_stall_cycles", n_low, 8);
    check("t5_error_out", error_out, 1'b1);
    check("t5_read_low", read, 1'b0);
    check("t5_valid_low", valid_out, 1'b0);
    step();
    check("t5_sticky", state, 3'd4);
    fifo_q.delete();
    exp_q.delete();
    fifo_full = 1'b0;
    init = 1'b1;
    step();
    check("t5_init_state", state, 3'd1);
    check("t5_init_err", error_out, 1'b0);
    init = 1'b0;
    step();
    check("t5_back_idle", state, 3'd2);

    // 6: reset in the middle of a stream
    p0 = pop_seen;
    load_words();
    ready_in = 1'b1;
    for (int i = 0; i < 60 && pop_seen < p0 + 4; i++) step();
    check("t6_streaming", (pop_seen >= p0 + 4), 1'b1);
    reset = 1'b1;
    #1;
    check("t6_read", read, 1'b0);
    check("t6_valid", valid_out, 1'b0);
    check("t6_state", state, 3'd0);
    check("t6_data", data_out, 6'd0);
    mon_en = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    p0 = pop_seen;
    repeat (3) step();
    check("t6_no_pop", pop_seen, p0);
    check("t6_held", state, 3'd0);
    reset = 1'b0;
    step();
    check("t6_rel_init", state, 3'd1);
    step();
    check("t6_rel_idle", state, 3'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
